// File: rtl/table_load_seq_if.sv
// Byte-stream load channel and registered read port of the table loader.
// The loader sits on the slave side; whoever feeds bytes and issues reads is the master.
interface table_load_seq_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [IDX_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output in_valid,
        output in_data,
        output rd_addr,
        input  in_ready,
        input  rd_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  rd_addr,
        output in_ready,
        output rd_data
    );
endinterface

// File: rtl/table_load_seq.sv
// Sequential loader filling a DEPTH-entry lookup table from a valid/ready byte stream,
// with a registered read port and a direct tap of entry 0's low nibble.
module table_load_seq #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 11,
    parameter int IDX_W   = 4,
    parameter int P_INDEX = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    table_load_seq_if.slave      bus,
    output logic                 load_done,
    output logic [3:0]           entry0_lo,
    output logic [IDX_W-1:0]     count,
    output logic                 ovf_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  wptr;
    logic [DATA_W-1:0] table_mem [DEPTH];
    logic              accept;
    logic              last_beat;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start pulse in any state (re)enters LOAD and blocks the beat of that cycle.
    always_comb begin
        state_next   = state;
        bus.in_ready = 1'b0;
        accept       = 1'b0;
        last_beat    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                bus.in_ready = !start;
                accept       = bus.in_valid && !start;
                last_beat    = accept && (wptr == LAST_IDX);
                if (start) begin
                    state_next = LOAD;
                end else if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // wptr parks on the last index so it never leaves the table; count reaches DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            count     <= '0;
            load_done <= 1'b0;
            ovf_err   <= 1'b0;
        end else if (start) begin
            wptr      <= '0;
            count     <= '0;
            load_done <= 1'b0;
            ovf_err   <= 1'b0;
        end else begin
            if (accept) begin
                count <= count + 1'b1;
                if (!last_beat) begin
                    wptr <= wptr + 1'b1;
                end
            end
            if (last_beat) begin
                load_done <= 1'b1;
            end
            if (bus.in_valid && (state != LOAD)) begin
                ovf_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_mem[i] <= '0;
            end
        end else if (start && (P_INDEX != 0)) begin
            for (int i = 0; i < DEPTH; i++) begin
                table_mem[i] <= '0;
            end
        end else if (accept) begin
            table_mem[wptr] <= bus.in_data;
        end
    end

    // Reads sample the table before any same-edge write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rd_data <= '0;
        end else if (bus.rd_addr < DEPTH_IDX) begin
            bus.rd_data <= table_mem[bus.rd_addr];
        end else begin
            bus.rd_data <= '0;
        end
    end

    assign entry0_lo = table_mem[0][3:0];

endmodule

// File: tb/tb_table_load_seq.sv
// Self-checking bench: drives one P_INDEX=0 and one P_INDEX=1 loader with the same
// stimulus and compares both against a behavioural table model.
module tb_table_load_seq;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 11;
    localparam int IDX_W  = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst       = 1'b1;
    logic             start_sig = 1'b0;
    logic             cur_valid = 1'b0;
    logic [7:0]       cur_data  = 8'h00;
    logic [3:0]       cur_addr  = 4'h0;

    logic [1:0]       done_v;
    logic [1:0]       ovf_v;
    logic [1:0]       ready_v;
    logic [1:0][3:0]  count_v;
    logic [1:0][3:0]  e0_v;
    logic [1:0][7:0]  rd_v;

    table_load_seq_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus0 ();
    table_load_seq_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus1 ();

    assign bus0.in_valid = cur_valid;
    assign bus0.in_data  = cur_data;
    assign bus0.rd_addr  = cur_addr;
    assign bus1.in_valid = cur_valid;
    assign bus1.in_data  = cur_data;
    assign bus1.rd_addr  = cur_addr;
    assign ready_v[0]    = bus0.in_ready;
    assign ready_v[1]    = bus1.in_ready;
    assign rd_v[0]       = bus0.rd_data;
    assign rd_v[1]       = bus1.rd_data;

    table_load_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .P_INDEX(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .start     (start_sig),
        .bus       (bus0.slave),
        .load_done (done_v[0]),
        .entry0_lo (e0_v[0]),
        .count     (count_v[0]),
        .ovf_err   (ovf_v[0])
    );

    table_load_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .P_INDEX(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start_sig),
        .bus       (bus1.slave),
        .load_done (done_v[1]),
        .entry0_lo (e0_v[1]),
        .count     (count_v[1]),
        .ovf_err   (ovf_v[1])
    );

    // Reference model: phase 0 idle, 1 loading, 2 complete; index p selects P_INDEX.
    logic [7:0] mm [2][DEPTH];
    logic [7:0] m_rd [2];
    int         m_phase = 0;
    int         m_cnt   = 0;
    bit         m_done  = 1'b0;
    bit         m_ovf   = 1'b0;
    logic [7:0] gap_data [DEPTH];

    int n_cmp  = 0;
    int n_fail = 0;

    function automatic bit exp_ready();
        return (m_phase == 1) && !start_sig;
    endfunction

    task automatic drive(input bit s, input bit v, input logic [7:0] d, input logic [3:0] a);
        start_sig = s;
        cur_valid = v;
        cur_data  = d;
        cur_addr  = a;
        #1;
    endtask

    task automatic tick();
        for (int p = 0; p < 2; p++) begin
            m_rd[p] = (cur_addr < DEPTH) ? mm[p][cur_addr] : 8'h00;
        end
        if (rst) begin
            m_phase = 0;
            m_cnt   = 0;
            m_done  = 1'b0;
            m_ovf   = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_rd[p] = 8'h00;
                for (int i = 0; i < DEPTH; i++) mm[p][i] = 8'h00;
            end
        end else if (start_sig) begin
            m_phase = 1;
            m_cnt   = 0;
            m_done  = 1'b0;
            m_ovf   = 1'b0;
            for (int i = 0; i < DEPTH; i++) mm[1][i] = 8'h00;
        end else if (cur_valid) begin
            if (m_phase != 1) begin
                m_ovf = 1'b1;
            end else begin
                mm[0][m_cnt] = cur_data;
                mm[1][m_cnt] = cur_data;
                m_cnt++;
                if (m_cnt == DEPTH) begin
                    m_phase = 2;
                    m_done  = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 0, 8'h00, 4'h0);
        tick();
        tick();
        for (int p = 0; p < 2; p++) begin
            n_cmp += 4;
            if (done_v[p] !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_load_done dut%0d got %0b want 0", p, done_v[p]); end
            if (ready_v[p] !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_ready dut%0d got %0b want 0", p, ready_v[p]); end
            if (count_v[p] !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_count dut%0d got %0d want 0", p, count_v[p]); end
            if (e0_v[p] !== 4'h0) begin n_fail++; $display("[TB] FAIL reset_entry0_lo dut%0d got %h want 0", p, e0_v[p]); end
        end
        rst = 1'b0;
        for (int a = 0; a < 16; a++) begin
            drive(0, 0, 8'h00, 4'(a));
            tick();
            for (int p = 0; p < 2; p++) begin
                n_cmp++;
                if (rd_v[p] !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rd_data dut%0d addr %0d got %h want 00", p, a, rd_v[p]); end
            end
        end
    endtask

    task automatic test_full_load();
        drive(1, 0, 8'h00, 4'h0);
        tick();
        for (int i = 0; i < DEPTH; i++) begin
            drive(0, 1, 8'(8'hA0 + i), 4'd5);
            for (int p = 0; p < 2; p++) begin
                n_cmp++;
                if (ready_v[p] !== 1'b1) begin n_fail++; $display("[TB] FAIL full_in_ready dut%0d beat %0d got %0b want 1", p, i, ready_v[p]); end
            end
            tick();
            for (int p = 0; p < 2; p++) begin
                n_cmp += 2;
                if (count_v[p] !== 4'(i + 1)) begin n_fail++; $display("[TB] FAIL full_count dut%0d beat %0d got %0d want %0d", p, i, count_v[p], i + 1); end
                if (done_v[p] !== (i == DEPTH - 1)) begin n_fail++; $display("[TB] FAIL full_load_done dut%0d beat %0d got %0b want %0b", p, i, done_v[p], i == DEPTH - 1); end
                if (i == 0) begin
                    n_cmp++;
                    if (e0_v[p] !== 4'h0) begin n_fail++; $display("[TB] FAIL full_entry0_lo dut%0d got %h want 0", p, e0_v[p]); end
                end
            end
        end
        drive(0, 0, 8'h00, 4'd5);
        tick();
        for (int p = 0; p < 2; p++) begin
            n_cmp += 2;
            if (rd_v[p] !== 8'hA5) begin n_fail++; $display("[TB] FAIL full_rd_addr5 dut%0d got %h want a5", p, rd_v[p]); end
            if (ready_v[p] !== 1'b0) begin n_fail++; $display("[TB] FAIL full_done_ready dut%0d got %0b want 0", p, ready_v[p]); end
        end
    endtask

    task automatic test_gaps();
        int cyc;
        int idx;
        bit v;
        for (int i = 0; i < DEPTH; i++) gap_data[i] = 8'($urandom);
        drive(1, 0, 8'h00, 4'h0);
        tick();
        cyc = 0;
        idx = 0;
        while (idx < DEPTH && cyc < 60) begin
            v = (cyc % 2) == 0;
            drive(0, v, gap_data[idx], 4'($urandom_range(0, 15)));
            for (int p = 0; p < 2; p++) begin
                n_cmp++;
                if (ready_v[p] !== exp_ready()) begin n_fail++; $display("[TB] FAIL gaps_in_ready dut%0d cyc %0d got %0b want %0b", p, cyc, ready_v[p], exp_ready()); end
            end
            tick();
            if (v) idx++;
            for (int p = 0; p < 2; p++) begin
                n_cmp += 3;
                if (count_v[p] !== 4'(idx)) begin n_fail++; $display("[TB] FAIL gaps_count dut%0d cyc %0d got %0d want %0d", p, cyc, count_v[p], idx); end
                if (done_v[p] !== (idx == DEPTH)) begin n_fail++; $display("[TB] FAIL gaps_load_done dut%0d cyc %0d got %0b want %0b", p, cyc, done_v[p], idx == DEPTH); end
                if (rd_v[p] !== m_rd[p]) begin n_fail++; $display("[TB] FAIL gaps_rd_data dut%0d cyc %0d got %h want %h", p, cyc, rd_v[p], m_rd[p]); end
            end
            cyc++;
        end
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0, 8'h00, 4'(a));
            tick();
            for (int p = 0; p < 2; p++) begin
                n_cmp++;
                if (rd_v[p] !== gap_data[a]) begin n_fail++; $display("[TB] FAIL gaps_readback dut%0d addr %0d got %h want %h", p, a, rd_v[p], gap_data[a]); end
            end
        end
    endtask

    task automatic test_overflow();
        drive(0, 1, 8'hFF, 4'h0);
        for (int p = 0; p < 2; p++) begin
            n_cmp++;
            if (ready_v[p] !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_in_ready dut%0d got %0b want 0", p, ready_v[p]); end
        end
        tick();
        drive(0, 0, 8'h00, 4'h0);
        tick();
        for (int p = 0; p < 2; p++) begin
            n_cmp += 3;
            if (ovf_v[p] !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_sticky dut%0d got %0b want 1", p, ovf_v[p]); end
            if (rd_v[p] !== gap_data[0]) begin n_fail++; $display("[TB] FAIL ovf_table_kept dut%0d got %h want %h", p, rd_v[p], gap_data[0]); end
            if (count_v[p] !== 4'd11) begin n_fail++; $display("[TB] FAIL ovf_count_hold dut%0d got %0d want 11", p, count_v[p]); end
        end
        drive(1, 0, 8'h00, 4'h0);
        tick();
        for (int p = 0; p < 2; p++) begin
            n_cmp += 3;
            if (ovf_v[p] !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_clear dut%0d got %0b want 0", p, ovf_v[p]); end
            if (done_v[p] !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_restart_done dut%0d got %0b want 0", p, done_v[p]); end
            if (e0_v[p] !== mm[p][0][3:0]) begin n_fail++; $display("[TB] FAIL ovf_restart_e0 dut%0d got %h want %h", p, e0_v[p], mm[p][0][3:0]); end
        end
    endtask

    task automatic test_restart();
        logic [7:0] beats [3];
        beats[0] = 8'h11;
        beats[1] = 8'h22;
        beats[2] = 8'h33;
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, beats[i], 4'h0);
            tick();
        end
        drive(1, 1, 8'h44, 4'h0);
        for (int p = 0; p < 2; p++) begin
            n_cmp++;
            if (ready_v[p] !== 1'b0) begin n_fail++; $display("[TB] FAIL restart_in_ready dut%0d got %0b want 0", p, ready_v[p]); end
        end
        tick();
        drive(0, 0, 8'h00, 4'd2);
        tick();
        n_cmp += 6;
        if (count_v[0] !== 4'd0) begin n_fail++; $display("[TB] FAIL restart_count dut0 got %0d want 0", count_v[0]); end
        if (count_v[1] !== 4'd0) begin n_fail++; $display("[TB] FAIL restart_count dut1 got %0d want 0", count_v[1]); end
        if (rd_v[0] !== 8'h33) begin n_fail++; $display("[TB] FAIL restart_entry2 dut0 got %h want 33", rd_v[0]); end
        if (rd_v[1] !== 8'h00) begin n_fail++; $display("[TB] FAIL restart_entry2 dut1 got %h want 00", rd_v[1]); end
        if (e0_v[0] !== 4'h1) begin n_fail++; $display("[TB] FAIL restart_entry0_lo dut0 got %h want 1", e0_v[0]); end
        if (e0_v[1] !== 4'h0) begin n_fail++; $display("[TB] FAIL restart_entry0_lo dut1 got %h want 0", e0_v[1]); end
        drive(0, 0, 8'h00, 4'd3);
        tick();
        n_cmp += 2;
        if (rd_v[0] !== gap_data[3]) begin n_fail++; $display("[TB] FAIL restart_persist dut0 got %h want %h", rd_v[0], gap_data[3]); end
        if (rd_v[1] !== 8'h00) begin n_fail++; $display("[TB] FAIL restart_persist dut1 got %h want 00", rd_v[1]); end
    endtask

    task automatic test_reset_mid_load();
        for (int i = 0; i < 6; i++) begin
            drive(0, 1, 8'($urandom), 4'h0);
            tick();
        end
        for (int p = 0; p < 2; p++) begin
            n_cmp++;
            if (count_v[p] !== 4'd6) begin n_fail++; $display("[TB] FAIL midrst_count6 dut%0d got %0d want 6", p, count_v[p]); end
        end
        rst = 1'b1;
        drive(0, 1, 8'($urandom), 4'h0);
        tick();
        rst = 1'b0;
        drive(0, 0, 8'h00, 4'd12);
        for (int p = 0; p < 2; p++) begin
            n_cmp += 4;
            if (ready_v[p] !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_in_ready dut%0d got %0b want 0", p, ready_v[p]); end
            if (count_v[p] !== 4'd0) begin n_fail++; $display("[TB] FAIL midrst_count dut%0d got %0d want 0", p, count_v[p]); end
            if (done_v[p] !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_load_done dut%0d got %0b want 0", p, done_v[p]); end
            if (e0_v[p] !== 4'h0) begin n_fail++; $display("[TB] FAIL midrst_entry0_lo dut%0d got %h want 0", p, e0_v[p]); end
        end
        tick();
        for (int p = 0; p < 2; p++) begin
            n_cmp++;
            if (rd_v[p] !== 8'h00) begin n_fail++; $display("[TB] FAIL midrst_addr12 dut%0d got %h want 00", p, rd_v[p]); end
        end
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0, 8'h00, 4'(a));
            tick();
            for (int p = 0; p < 2; p++) begin
                n_cmp++;
                if (rd_v[p] !== 8'h00) begin n_fail++; $display("[TB] FAIL midrst_cleared dut%0d addr %0d got %h want 00", p, a, rd_v[p]); end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 15) == 0, $urandom_range(0, 9) < 7, 8'($urandom), 4'($urandom_range(0, 15)));
            for (int p = 0; p < 2; p++) begin
                n_cmp++;
                if (ready_v[p] !== exp_ready() && !rst) begin n_fail++; $display("[TB] FAIL rand_in_ready dut%0d cyc %0d got %0b want %0b", p, c, ready_v[p], exp_ready()); end
            end
            tick();
            for (int p = 0; p < 2; p++) begin
                n_cmp += 5;
                if (count_v[p] !== 4'(m_cnt)) begin n_fail++; $display("[TB] FAIL rand_count dut%0d cyc %0d got %0d want %0d", p, c, count_v[p], m_cnt); end
                if (done_v[p] !== m_done) begin n_fail++; $display("[TB] FAIL rand_load_done dut%0d cyc %0d got %0b want %0b", p, c, done_v[p], m_done); end
                if (ovf_v[p] !== m_ovf) begin n_fail++; $display("[TB] FAIL rand_ovf_err dut%0d cyc %0d got %0b want %0b", p, c, ovf_v[p], m_ovf); end
                if (e0_v[p] !== mm[p][0][3:0]) begin n_fail++; $display("[TB] FAIL rand_entry0_lo dut%0d cyc %0d got %h want %h", p, c, e0_v[p], mm[p][0][3:0]); end
                if (rd_v[p] !== m_rd[p]) begin n_fail++; $display("[TB] FAIL rand_rd_data dut%0d cyc %0d got %h want %h", p, c, rd_v[p], m_rd[p]); end
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_full_load();
        test_gaps();
        test_overflow();
        test_restart();
        test_reset_mid_load();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
